// File: rtl/nn_pkg.sv
// Shared definitions for the layer MAC engines: datapath widths, FSM encoding and
// the per-layer sizes of the network.
package nn_pkg;

    localparam int ACT_W  = 8;
    localparam int W_W    = 8;
    localparam int PROD_W = ACT_W + W_W;
    localparam int ACCW   = 32;

    localparam int unsigned L1_N_IN  = 784;
    localparam int unsigned L1_N_OUT = 128;
    localparam int unsigned L2_N_IN  = 128;
    localparam int unsigned L2_N_OUT = 32;
    localparam int unsigned L3_N_IN  = 32;
    localparam int unsigned L3_N_OUT = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/relu_sat.sv
// Output quantiser: arithmetic right shift of the accumulator, then ReLU and
// saturation to the 0..127 range.
module relu_sat
    import nn_pkg::*;
#(
    parameter int unsigned SHIFT = 7
) (
    input  logic signed [ACCW-1:0] acc,
    output logic        [7:0]      q
);

    logic signed [ACCW-1:0] shifted;

    always_comb begin
        shifted = acc >>> SHIFT;
        q       = 8'd0;
        if (shifted < 0) begin
            q = 8'd0;
        end else if (shifted > 127) begin
            q = 8'd127;
        end else begin
            q = shifted[7:0];
        end
    end

endmodule

// File: rtl/layer_mac_engine.sv
// One fully connected layer: streams activations and neuron-major weights, accumulates
// each neuron's dot product and writes the quantised ReLU result to the output buffer.
module layer_mac_engine
    import nn_pkg::*;
#(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_OUT = 128,
    parameter int unsigned SHIFT = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic        [15:0]      act_rd_addr,
    input  logic signed [ACT_W-1:0] act_rd_data,
    output logic        [19:0]      w_rd_addr,
    input  logic signed [W_W-1:0]   w_rd_data,
    output logic                    out_we,
    output logic        [15:0]      out_addr,
    output logic        [7:0]       out_data,
    output logic                    busy,
    output logic                    done
);

    state_e                 state_q;
    logic        [15:0]     i_q;
    logic        [15:0]     j_q;
    logic        [19:0]     w_q;
    logic signed [ACCW-1:0] acc_q;
    logic                   valid_q;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACCW-1:0]   prod_ext;
    logic        [7:0]        relu_q;

    assign prod     = act_rd_data * w_rd_data;
    assign prod_ext = {{(ACCW - PROD_W){prod[PROD_W-1]}}, prod};

    relu_sat #(
        .SHIFT (SHIFT)
    ) u_relu_sat (
        .acc (acc_q),
        .q   (relu_q)
    );

    assign act_rd_addr = i_q;
    assign w_rd_addr   = w_q;
    assign busy        = (state_q == StLoad) || (state_q == StDrain) || (state_q == StWrite);
    assign done        = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            i_q      <= '0;
            j_q      <= '0;
            w_q      <= '0;
            acc_q    <= '0;
            valid_q  <= 1'b0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else if (busy && !run) begin
            // Abort: drop the partial neuron, including any write due this cycle.
            state_q <= StIdle;
            acc_q   <= '0;
            valid_q <= 1'b0;
            out_we  <= 1'b0;
        end else begin
            out_we  <= 1'b0;
            valid_q <= 1'b0;
            if (valid_q) begin
                acc_q <= acc_q + prod_ext;
            end
            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q <= StLoad;
                        i_q     <= '0;
                        j_q     <= '0;
                        w_q     <= '0;
                        acc_q   <= '0;
                    end
                end
                StLoad: begin
                    valid_q <= 1'b1;
                    // w_q runs straight on into the next neuron's row.
                    w_q     <= w_q + 20'd1;
                    if (i_q == 16'(N_IN - 1)) begin
                        state_q <= StDrain;
                    end else begin
                        i_q <= i_q + 16'd1;
                    end
                end
                StDrain: begin
                    state_q <= StWrite;
                end
                StWrite: begin
                    out_we   <= 1'b1;
                    out_addr <= j_q;
                    out_data <= relu_q;
                    acc_q    <= '0;
                    if (j_q == 16'(N_OUT - 1)) begin
                        state_q <= StDone;
                    end else begin
                        j_q     <= j_q + 16'd1;
                        i_q     <= '0;
                        state_q <= StLoad;
                    end
                end
                StDone: begin
                    if (!run) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/layer_mac_engine.md
LAYER_MAC_ENGINE -- requirements
Module: layer_mac_engine

Interface
REQ-001 The block SHALL take parameter N_IN, default 784: input activations per neuron.
REQ-002 The block SHALL take parameter N_OUT, default 128: neurons in the layer.
REQ-003 The block SHALL take parameter SHIFT, default 7: arithmetic right-shift applied before output quantisation.
REQ-004 The block SHALL use ACCW = 32 for the accumulator width and 8-bit signed activations and weights.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 run  in  1  level from the sequencer; high = process layer, low = release/abort.
REQ-008 act_rd_addr  out  16  activation buffer read address.
REQ-009 act_rd_data  in  8  signed activation; valid 1 cycle after its address.
REQ-010 w_rd_addr  out  20  weight ROM read address, neuron-major: j*N_IN+i.
REQ-011 w_rd_data  in  8  signed weight; valid 1 cycle after its address.
REQ-012 out_we  out  1  output buffer write strobe.
REQ-013 out_addr  out  16  output neuron index j.
REQ-014 out_data  out  8  signed quantised result, range 0..127.
REQ-015 busy  out  1  high in LOAD, DRAIN and WRITE.
REQ-016 done  out  1  level; high in DONE only.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, DRAIN, WRITE and DONE.
REQ-018 IDLE: when run=1, go to LOAD and clear i, j, acc and w_rd_addr to 0.
REQ-019 LOAD: drive act_rd_addr=i and w_rd_addr=j*N_IN+i from registered counters (w_rd_addr incremented, no multiplier); increment i; when i=N_IN-1, go to DRAIN.
REQ-020 A registered valid flag SHALL trail each LOAD cycle by 1; while it is set, acc <= acc + sext(act_rd_data*w_rd_data).
REQ-021 DRAIN: accumulate the last product, then go to WRITE.
REQ-022 WRITE: out_we=1 for exactly 1 cycle, out_addr=j, out_data=clamp(acc>>>SHIFT, 0, 127); acc <= 0.
REQ-023 WRITE exit: if j=N_OUT-1, go to DONE; otherwise j++, i=0 and go to LOAD.
REQ-024 Each neuron SHALL take exactly N_IN+2 cycles.
REQ-025 The first out_we SHALL assert N_IN+2 cycles after the run-sampling edge, and done SHALL assert N_OUT*(N_IN+2) cycles after it.
REQ-026 The products SHALL be signed 8x8 to 16 bits, sign-extended to ACCW; the accumulator SHALL wrap modulo 2^ACCW without saturation.
REQ-027 ReLU/saturation: shifted value <0 gives 0; >127 gives 127; otherwise the low 8 bits.
REQ-028 DONE: done=1 while run=1; when run=0, go to IDLE with done=0 on the next cycle.
REQ-029 run=0 in LOAD, DRAIN or WRITE SHALL abort to IDLE next cycle: a WRITE in that cycle is suppressed, done never asserts, and acc is cleared.
REQ-030 run held high in IDLE directly after DONE cannot occur, since DONE exits only on run=0; a new run edge restarts from j=0.
REQ-031 N_IN=1 and N_OUT=1 SHALL be legal; LOAD then lasts 1 cycle.

Reset
REQ-032 rst=1 SHALL force state=IDLE, i=j=0, acc=0, valid=0 and every output to 0 on the next edge, in any state, including mid-layer.
REQ-033 rst SHALL take priority over run.

Structure
REQ-034 Shared package nn_pkg SHALL hold the state encoding, the activation/weight/accumulator widths, and the per-layer N_IN/N_OUT constants (784/128, 128/32, 32/10).
REQ-035 One sub-module, relu_sat, SHALL implement the combinational shift-and-clamp from ACCW to 8 bits.
REQ-036 The MAC datapath SHALL stay inline.

Verification
REQ-037 The bench SHALL run N_IN=4, N_OUT=2, SHIFT=0, acts {1,2,3,4}, weights n0 {1,1,1,1} and n1 {-1,-1,-1,-1}, with run held -> writes (0,10) then (1,0); done high at cycle 12; out_we never asserts twice per neuron.
REQ-038 The bench SHALL drive the saturation case: acts all 127, weights all 127, N_IN=4, SHIFT=7 -> out_data=127.
REQ-039 The bench SHALL drive the shift boundary case: acc=255 with SHIFT=1 -> 127; acc=-1 with SHIFT=7 -> 0.
REQ-040 The bench SHALL drop run at cycle 5 of neuron 0 -> IDLE next cycle, no out_we, done stays 0; re-asserting run restarts with w_rd_addr=0.
REQ-041 The bench SHALL assert rst during WRITE of neuron 1 -> out_we=0 and done=0 next cycle, all outputs 0.
REQ-042 The bench SHALL use the done handshake: hold run 3 cycles after done -> done stays 1; drop run -> done=0 one cycle later, busy=0.
